// File: rtl/data_mem_lsu_if.sv
// rtl/data_mem_lsu_if.sv - request/response bus between the load/store stage and data_mem_lsu
interface data_mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - word RAM load/store unit with wait states and split misaligned beats (optional MISALIGN_TRAP_EN)
module data_mem_lsu #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    data_mem_lsu_if.slave bus
);

    localparam int IW    = ADDR_WIDTH - 2;
    localparam int WORDS = 2 ** IW;
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t state, next_state;

    // captured request
    logic                  q_write;
    logic [2:0]            q_funct3;
    logic [ADDR_WIDTH-1:0] q_addr;
    logic [31:0]           q_wdata;
    logic                  q_err;
    logic                  q_cross;

    // request decode (evaluated on the live bus while IDLE)
    logic [2:0]            req_size;
    logic                  req_legal;
    logic                  req_range_err;
    logic                  req_cross;
    logic                  req_err;
    logic [ADDR_WIDTH:0]   req_end_excl;
`ifdef MISALIGN_TRAP_EN
    logic                  req_misalign;
`endif

    // beat sequencing and RAM port
    logic [3:0]            wait_cnt;
    logic                  beat_last;
    logic                  beat_sel;
    logic                  ram_en;
    logic [IW-1:0]         widx0;
    logic [IW-1:0]         widx1;
    logic [IW-1:0]         ram_idx;
    logic [3:0]            ram_be;
    logic [31:0]           ram_wdata;
    logic [31:0]           rd_word;
    logic [31:0]           ld_lo;

    // store lane shaping and load assembly
    logic [2:0]            q_size;
    logic [3:0]            lane_mask;
    logic [4:0]            byte_shift;
    logic [63:0]           wide_wdata;
    logic [7:0]            wide_be;
    logic [31:0]           ld_lo_word;
    logic [31:0]           ld_raw;
    logic [31:0]           ld_data;

    // registered response
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [31:0]           rsp_rdata_q;

    logic [31:0]           mem [WORDS];

    // classify an incoming request: size, legality, range and word crossing
    always_comb begin
        case (bus.req_funct3[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            2'b10:   req_size = 3'd4;
            default: req_size = 3'd0;
        endcase
        if (bus.req_write) begin
            req_legal = !bus.req_funct3[2] && (bus.req_funct3[1:0] != 2'b11);
        end else begin
            req_legal = (bus.req_funct3[1:0] != 2'b11) && !(bus.req_funct3[2] && bus.req_funct3[1]);
        end
        // one past the last byte touched; exceeding the capacity means the access runs off the end
        req_end_excl  = {1'b0, bus.req_addr[ADDR_WIDTH-1:0]} + (ADDR_WIDTH + 1)'(req_size);
        req_range_err = (|bus.req_addr[31:ADDR_WIDTH]) || (req_end_excl > MEM_BYTES);
        req_cross     = ({1'b0, bus.req_addr[1:0]} + req_size) > 3'd4;
        req_err       = !req_legal || req_range_err;
`ifdef MISALIGN_TRAP_EN
        req_misalign  = ((req_size == 3'd2) && bus.req_addr[0]) ||
                        ((req_size == 3'd4) && (bus.req_addr[1:0] != 2'b00));
        req_err       = req_err || req_misalign;
`endif
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state; the RAM is touched only in the last cycle of a beat
    always_comb begin
        next_state = state;
        bus.req_ready = 1'b0;
        ram_en = 1'b0;
        beat_sel = 1'b0;
        beat_last = (wait_cnt == 4'(WAIT_STATES));
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    next_state = BEAT0;
                end
            end
            BEAT0: begin
                // rejected accesses spend one decode cycle, then respond with no RAM activity
                if (q_err) begin
                    next_state = RESP;
                end else if (beat_last) begin
                    ram_en = 1'b1;
                    next_state = q_cross ? BEAT1 : RESP;
                end
            end
            BEAT1: begin
                beat_sel = 1'b1;
                if (beat_last) begin
                    ram_en = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // wait-state counter restarts on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (state != next_state) begin
            wait_cnt <= 4'd0;
        end else if ((state == BEAT0) || (state == BEAT1)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // capture the request payload on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_write  <= 1'b0;
            q_funct3 <= 3'd0;
            q_addr   <= '0;
            q_wdata  <= 32'd0;
            q_err    <= 1'b0;
            q_cross  <= 1'b0;
        end else if ((state == IDLE) && bus.req_valid) begin
            q_write  <= bus.req_write;
            q_funct3 <= bus.req_funct3;
            q_addr   <= bus.req_addr[ADDR_WIDTH-1:0];
            q_wdata  <= bus.req_wdata;
            q_err    <= req_err;
            q_cross  <= req_cross;
        end
    end

    // spread store data/byte enables over two adjacent words and pick this beat's half
    always_comb begin
        case (q_funct3[1:0])
            2'b00:   q_size = 3'd1;
            2'b01:   q_size = 3'd2;
            default: q_size = 3'd4;
        endcase
        case (q_size)
            3'd1:    lane_mask = 4'b0001;
            3'd2:    lane_mask = 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
        byte_shift = {q_addr[1:0], 3'b000};
        wide_wdata = {32'd0, q_wdata} << byte_shift;
        wide_be    = {4'b0000, lane_mask} << q_addr[1:0];
        widx0      = q_addr[ADDR_WIDTH-1:2];
        widx1      = widx0 + IW'(1);
        ram_idx    = beat_sel ? widx1 : widx0;
        ram_be     = beat_sel ? wide_be[7:4] : wide_be[3:0];
        ram_wdata  = beat_sel ? wide_wdata[63:32] : wide_wdata[31:0];
        rd_word    = mem[ram_idx];
    end

    // RAM byte-lane writes and first-beat load buffer; contents are not reset
    always_ff @(posedge clk) begin
        if (ram_en && q_write) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) begin
                    mem[ram_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
                end
            end
        end
        if (ram_en && !beat_sel) begin
            ld_lo <= rd_word;
        end
    end

    // assemble load bytes little-endian across the word pair and extend
    always_comb begin
        ld_lo_word = beat_sel ? ld_lo : rd_word;
        ld_raw     = 32'({rd_word, ld_lo_word} >> byte_shift);
        case (q_funct3)
            3'b000:  ld_data = {{24{ld_raw[7]}}, ld_raw[7:0]};
            3'b100:  ld_data = {24'd0, ld_raw[7:0]};
            3'b001:  ld_data = {{16{ld_raw[15]}}, ld_raw[15:0]};
            3'b101:  ld_data = {16'd0, ld_raw[15:0]};
            default: ld_data = ld_raw;
        endcase
    end

    // response registers load on entry to RESP and clear otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            rsp_valid_q <= (next_state == RESP);
            rsp_err_q   <= (next_state == RESP) && q_err;
            rsp_rdata_q <= ((next_state == RESP) && ram_en && !q_write) ? ld_data : 32'd0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - scoreboard bench for data_mem_lsu with zero and two wait states
module tb_data_mem_lsu;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        int          tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t qa[$];
    exp_t qb[$];
    int   acc_a = 0;
    int   acc_b = 0;
    logic busy_a = 1'b0;
    logic busy_b = 1'b0;
    exp_t ea;
    exp_t eb;

    data_mem_lsu_if ifa();
    data_mem_lsu_if ifb();

    data_mem_lsu #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut_a (.clk(clk), .rst_n(rst_a_n), .bus(ifa));
    data_mem_lsu #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut_b (.clk(clk), .rst_n(rst_b_n), .bus(ifb));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s tag=%0d got=%h want=%h", name, tag, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        if (d == 0) begin
            ifa.req_valid = v; ifa.req_write = wr; ifa.req_funct3 = f3;
            ifa.req_addr = a; ifa.req_wdata = wd;
        end else begin
            ifb.req_valid = v; ifb.req_write = wr; ifb.req_funct3 = f3;
            ifb.req_addr = a; ifb.req_wdata = wd;
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? ifa.req_ready : ifb.req_ready;
    endfunction

    function automatic int qlen(input int d);
        return (d == 0) ? qa.size() : qb.size();
    endfunction

    task automatic issue(input int d, input int tag, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int lat);
        exp_t e;
        int   n;
        @(negedge clk);
        drive(d, 1'b1, wr, f3, a, wd);
        n = 0;
        while (!rdy(d) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy(d)) begin
            total++; bad++;
            $display("FAIL accept_timeout tag=%0d got=0 want=1", tag);
            drive(d, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
            return;
        end
        e.rdata = exp_rd; e.err = exp_err; e.cyc = cyc + 1 + lat; e.tag = tag;
        if (d == 0) begin
            acc_a = cyc + 1; busy_a = 1'b0; qa.push_back(e);
        end else begin
            acc_b = cyc + 1; busy_b = 1'b0; qb.push_back(e);
        end
        @(posedge clk);
        #1;
        drive(d, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        n = 0;
        while (qlen(d) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (qlen(d) != 0) begin
            total++; bad++;
            $display("FAIL rsp_timeout tag=%0d got=none want=rsp", tag);
            if (d == 0) qa.delete(); else qb.delete();
        end
    endtask

    // scoreboard monitor for the zero-wait-state instance
    always @(negedge clk) begin
        if (qa.size() != 0 && cyc >= acc_a && ifa.req_ready) busy_a = 1'b1;
        if (ifa.rsp_valid) begin
            if (qa.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_rsp_a got=1 want=0");
            end else begin
                ea = qa.pop_front();
                check("rdata_a", ea.tag, ifa.rsp_rdata, ea.rdata);
                check("err_a", ea.tag, {31'd0, ifa.rsp_err}, {31'd0, ea.err});
                check("lat_a", ea.tag, 32'(cyc), 32'(ea.cyc));
                check("ready_busy_a", ea.tag, {31'd0, busy_a}, 32'd0);
                busy_a = 1'b0;
            end
        end
    end

    // scoreboard monitor for the two-wait-state instance
    always @(negedge clk) begin
        if (qb.size() != 0 && cyc >= acc_b && ifb.req_ready) busy_b = 1'b1;
        if (ifb.rsp_valid) begin
            if (qb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_rsp_b got=1 want=0");
            end else begin
                eb = qb.pop_front();
                check("rdata_b", eb.tag, ifb.rsp_rdata, eb.rdata);
                check("err_b", eb.tag, {31'd0, ifb.rsp_err}, {31'd0, eb.err});
                check("lat_b", eb.tag, 32'(cyc), 32'(eb.cyc));
                check("ready_busy_b", eb.tag, {31'd0, busy_b}, 32'd0);
                busy_b = 1'b0;
            end
        end
    end

    task automatic run_a();
        issue(0, 1,  1'b1, F_W,    32'h010, 32'hDEADBEEF, 32'h0,        1'b0, 1);
        issue(0, 2,  1'b0, F_W,    32'h010, 32'h0,        32'hDEADBEEF, 1'b0, 1);
        issue(0, 3,  1'b0, F_B,    32'h013, 32'h0,        32'hFFFFFFDE, 1'b0, 1);
        issue(0, 4,  1'b0, F_BU,   32'h013, 32'h0,        32'h000000DE, 1'b0, 1);
        issue(0, 5,  1'b0, F_H,    32'h012, 32'h0,        32'hFFFFDEAD, 1'b0, 1);
        issue(0, 6,  1'b0, F_HU,   32'h010, 32'h0,        32'h0000BEEF, 1'b0, 1);
        issue(0, 7,  1'b1, F_W,    32'h004, 32'hCAFEF00D, 32'h0,        1'b0, 1);
        issue(0, 8,  1'b1, F_W,    32'h008, 32'h99999999, 32'h0,        1'b0, 1);
        issue(0, 9,  1'b1, F_W,    32'h006, 32'h11223344, 32'h0,        1'b0, 2);
        issue(0, 10, 1'b0, F_W,    32'h006, 32'h0,        32'h11223344, 1'b0, 2);
        issue(0, 11, 1'b0, F_HU,   32'h007, 32'h0,        32'h00002233, 1'b0, 2);
        issue(0, 12, 1'b0, F_W,    32'h004, 32'h0,        32'h3344F00D, 1'b0, 1);
        issue(0, 13, 1'b0, F_W,    32'h008, 32'h0,        32'h99991122, 1'b0, 1);
        issue(0, 14, 1'b1, F_H,    32'h00B, 32'h00007E81, 32'h0,        1'b0, 2);
        issue(0, 15, 1'b0, F_W,    32'h008, 32'h0,        32'h81991122, 1'b0, 1);
        issue(0, 16, 1'b0, F_B,    32'h00C, 32'h0,        32'h0000007E, 1'b0, 1);
        issue(0, 17, 1'b0, F_H,    32'h00B, 32'h0,        32'h00007E81, 1'b0, 2);
        issue(0, 18, 1'b0, F_B,    32'h00B, 32'h0,        32'hFFFFFF81, 1'b0, 1);
        issue(0, 19, 1'b0, 3'b011, 32'h010, 32'h0,        32'h0,        1'b1, 1);
        issue(0, 20, 1'b1, 3'b011, 32'h010, 32'h12345678, 32'h0,        1'b1, 1);
        issue(0, 21, 1'b1, F_W,    32'h3FC, 32'h12345678, 32'h0,        1'b0, 1);
        issue(0, 22, 1'b1, F_W,    32'h3FE, 32'hAABBCCDD, 32'h0,        1'b1, 1);
        issue(0, 23, 1'b0, F_W,    32'h3FC, 32'h0,        32'h12345678, 1'b0, 1);
        issue(0, 24, 1'b0, F_BU,   32'h3FF, 32'h0,        32'h00000012, 1'b0, 1);
        issue(0, 25, 1'b0, F_W,    32'h3FD, 32'h0,        32'h0,        1'b1, 1);
        issue(0, 26, 1'b0, F_B,    32'h80000000, 32'h0,   32'h0,        1'b1, 1);
        issue(0, 27, 1'b0, F_H,    32'h3FF, 32'h0,        32'h0,        1'b1, 1);
        issue(0, 28, 1'b0, F_HU,   32'h3FE, 32'h0,        32'h00001234, 1'b0, 1);
        issue(0, 29, 1'b0, F_W,    32'h010, 32'h0,        32'hDEADBEEF, 1'b0, 1);
        issue(0, 30, 1'b1, F_W,    32'h00C, 32'h01020304, 32'h0,        1'b0, 1);
        issue(0, 31, 1'b1, F_W,    32'h010, 32'h55667788, 32'h0,        1'b0, 1);
        // reset lands in BEAT1 of a crossing store: only the first beat's lanes stick
        @(negedge clk);
        drive(0, 1'b1, 1'b1, F_W, 32'h00E, 32'hAABBCCDD);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_a_n = 1'b0;
        #1;
        check("midrst_valid", 99, {31'd0, ifa.rsp_valid}, 32'd0);
        check("midrst_err",   99, {31'd0, ifa.rsp_err},   32'd0);
        check("midrst_rdata", 99, ifa.rsp_rdata,           32'd0);
        check("midrst_ready", 99, {31'd0, ifa.req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_a_n = 1'b1;
        issue(0, 32, 1'b0, F_W,    32'h00C, 32'h0,        32'hCCDD0304, 1'b0, 1);
        issue(0, 33, 1'b0, F_W,    32'h010, 32'h0,        32'h55667788, 1'b0, 1);
        issue(0, 34, 1'b1, F_B,    32'h011, 32'hFFFFFF00, 32'h0,        1'b0, 1);
        issue(0, 35, 1'b0, F_W,    32'h010, 32'h0,        32'h55660088, 1'b0, 1);
    endtask

    task automatic run_b();
        issue(1, 101, 1'b1, F_W,    32'h004, 32'hCAFEF00D, 32'h0,        1'b0, 3);
        issue(1, 102, 1'b1, F_W,    32'h008, 32'h99999999, 32'h0,        1'b0, 3);
        issue(1, 103, 1'b1, F_W,    32'h006, 32'h11223344, 32'h0,        1'b0, 6);
        issue(1, 104, 1'b0, F_W,    32'h004, 32'h0,        32'h3344F00D, 1'b0, 3);
        issue(1, 105, 1'b0, F_W,    32'h006, 32'h0,        32'h11223344, 1'b0, 6);
        issue(1, 106, 1'b0, 3'b111, 32'h004, 32'h0,        32'h0,        1'b1, 1);
        issue(1, 107, 1'b0, F_HU,   32'h007, 32'h0,        32'h00002233, 1'b0, 6);
    endtask

    initial begin
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_valid_a", 0, {31'd0, ifa.rsp_valid}, 32'd0);
        check("rst_err_a",   0, {31'd0, ifa.rsp_err},   32'd0);
        check("rst_rdata_a", 0, ifa.rsp_rdata,           32'd0);
        check("rst_ready_a", 0, {31'd0, ifa.req_ready}, 32'd1);
        check("rst_valid_b", 0, {31'd0, ifb.rsp_valid}, 32'd0);
        check("rst_ready_b", 0, {31'd0, ifb.req_ready}, 32'd1);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        fork
            run_a();
            run_b();
        join
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1);
    end

endmodule
